// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Purpose  : 8N1 UART receiver. The line is synchronised and sampled mid-bit
//            using a baud counter derived from CLOCK_RATE / BAUD_RATE.
//            A received byte is published only when its stop bit is sampled
//            high; a low stop bit is reported as a framing error instead.
// Ports    : i_clk          - system clock, rising edge
//            i_rst_n        - asynchronous active-low reset
//            i_Rx_Serial    - asynchronous serial line, idle high
//            o_Rx_Byte      - last correctly framed byte (LSB first on wire)
//            o_Rx_Valid     - one-cycle pulse when o_Rx_Byte is updated
//            o_Rx_Frame_Err - one-cycle pulse when a stop bit is sampled low
//            o_Rx_Busy      - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx #(
  parameter int BAUD_RATE  = 115_200,
  parameter int CLOCK_RATE = 27_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_Rx_Serial,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Valid,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Busy
);

  localparam logic [31:0] DIV  = 32'(CLOCK_RATE / BAUD_RATE);
  localparam logic [31:0] HALF = DIV / 32'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        sync_1, rx_s;
  logic [31:0] cnt, cnt_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  byte_nxt;
  logic        valid_nxt, err_nxt;
  logic        armed, armed_nxt;
  logic        stop_bad, stop_bad_nxt;

  // Two-flop synchroniser; flops reset to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= i_Rx_Serial;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      cnt            <= 32'd0;
      bit_idx        <= 3'd0;
      shift          <= 8'h00;
      o_Rx_Byte      <= 8'h00;
      o_Rx_Valid     <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
      armed          <= 1'b0;
      stop_bad       <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bit_idx        <= bit_idx_nxt;
      shift          <= shift_nxt;
      o_Rx_Byte      <= byte_nxt;
      o_Rx_Valid     <= valid_nxt;
      o_Rx_Frame_Err <= err_nxt;
      armed          <= armed_nxt;
      stop_bad       <= stop_bad_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    byte_nxt     = o_Rx_Byte;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;
    armed_nxt    = armed;
    stop_bad_nxt = stop_bad;

    case (state)
      IDLE: begin
        cnt_nxt     = 32'd0;
        bit_idx_nxt = 3'd0;
        // A high line re-arms the receiver; without this a break (held-low
        // line) after a framing error would look like an endless start bit.
        if (rx_s) begin
          armed_nxt = 1'b1;
        end
        if (armed && !rx_s) begin
          state_nxt = START;
        end
      end

      START: begin
        if (cnt == HALF - 32'd1) begin
          cnt_nxt   = 32'd0;
          // Still low at mid start bit: genuine start. High: glitch.
          state_nxt = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      DATA: begin
        if (cnt == DIV - 32'd1) begin
          cnt_nxt            = 32'd0;
          shift_nxt[bit_idx] = rx_s;
          bit_idx_nxt        = bit_idx + 3'd1;  // wraps to 0 after bit 7
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      STOP: begin
        if (cnt == DIV - 32'd1) begin
          cnt_nxt   = 32'd0;
          state_nxt = CLEANUP;
          if (rx_s) begin
            byte_nxt     = shift;
            valid_nxt    = 1'b1;
            stop_bad_nxt = 1'b0;
          end else begin
            err_nxt      = 1'b1;
            stop_bad_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end

      CLEANUP: begin
        cnt_nxt      = 32'd0;
        state_nxt    = IDLE;
        stop_bad_nxt = 1'b0;
        if (stop_bad) begin
          armed_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = 32'd0;
        bit_idx_nxt = 3'd0;
      end
    endcase
  end

  assign o_Rx_Busy = (state != IDLE);

endmodule
`default_nettype wire

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate in bits/s.
REQ-002 SHALL have parameter CLOCK_RATE, default 27_000_000, meaning the i_clk frequency in Hz.
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_Rx_Serial  input  1  asynchronous UART line; idle high.
REQ-006 SHALL have port o_Rx_Byte  output  8  last correctly framed byte, LSB = first data bit.
REQ-007 SHALL have port o_Rx_Valid  output  1  one-cycle pulse when o_Rx_Byte is updated.
REQ-008 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 SHALL have port o_Rx_Busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL define DIV = CLOCK_RATE/BAUD_RATE (integer division; 234 at defaults) and HALF = DIV/2 (117 at defaults).
REQ-011 SHALL pass i_Rx_Serial through a 2-flop synchronizer; all decisions use the second flop (rx_s), giving 2 cycles of input latency.
REQ-012 SHALL use a state machine with states IDLE, START, DATA, STOP, CLEANUP; any other encoding SHALL go to IDLE on the next cycle.
REQ-013 SHALL use a baud counter at least 32 bits wide, cleared to 0 on every state transition, and a 3-bit bit index.
REQ-014 IDLE: SHALL hold the counter and bit index at 0; SHALL go to START when armed=1 and rx_s=0.
REQ-015 armed SHALL be set by any cycle in IDLE with rx_s=1, and SHALL be cleared on entry to IDLE from CLEANUP after a frame error; a held-low line (break) therefore SHALL NOT retrigger reception.
REQ-016 START: SHALL increment the counter until it equals HALF-1, then sample rx_s; 0 -> DATA; 1 -> IDLE (glitch rejected, no pulse output).
REQ-017 DATA: SHALL increment the counter until it equals DIV-1, then shift rx_s into a shift register at position bit index (LSB first), clear the counter, and increment the bit index; after index 7 SHALL go to STOP with the index wrapping to 0.
REQ-018 STOP: at counter = DIV-1 SHALL sample rx_s and go to CLEANUP; 1 -> load o_Rx_Byte from the shift register and pulse o_Rx_Valid for one cycle; 0 -> pulse o_Rx_Frame_Err for one cycle and leave o_Rx_Byte unchanged.
REQ-019 CLEANUP: SHALL last exactly one cycle, then go to IDLE.
REQ-020 o_Rx_Valid and o_Rx_Frame_Err SHALL never be high in the same cycle.
REQ-021 Every sampling point SHALL fall mid-bit: the start bit is sampled HALF cycles after the detected falling edge, and each following bit is sampled DIV cycles after the previous sample.
REQ-022 From the synchronized falling edge of the start bit, o_Rx_Valid SHALL assert HALF + 9*DIV cycles later (±1 cycle, fixed by the implementation and documented in the testbench).
REQ-023 Line activity during CLEANUP SHALL be ignored; a start bit beginning in that cycle SHALL be detected in IDLE on the next cycle.

Reset
REQ-024 On i_rst_n=0, the block SHALL immediately set: state=IDLE, counter=0, bit index=0, shift register=0x00, o_Rx_Byte=0x00, o_Rx_Valid=0, o_Rx_Frame_Err=0, o_Rx_Busy=0, armed=0, synchronizer flops=1.
REQ-025 A reset asserted mid-frame SHALL discard the partial byte and SHALL NOT produce any pulse; after release, reception SHALL require rx_s=1 for at least one cycle (armed) before a start bit is accepted.

Verification
REQ-026 Defaults, drive 0xA5 framed 8N1 at 234 clocks/bit -> exactly one o_Rx_Valid pulse, o_Rx_Byte=0xA5, o_Rx_Frame_Err stays 0, o_Rx_Busy falls after CLEANUP.
REQ-027 Back-to-back 0x00 then 0xFF with no idle gap -> two o_Rx_Valid pulses, bytes 0x00 then 0xFF, each at the latency defined in REQ-022 from its own start edge.
REQ-028 Low glitch of 50 clocks on an idle line -> START is entered, the machine returns to IDLE, there is no pulse, and o_Rx_Byte is unchanged.
REQ-029 Frame 0x3C with the stop bit driven low, then the line held low for 5 bit times, then 0x81 -> one o_Rx_Frame_Err pulse, o_Rx_Byte keeps its prior value, there is no retrigger during the break, then a valid 0x81 is received.
REQ-030 i_rst_n pulsed low during data bit 4 of a frame, then a clean 0x5A -> no pulse for the aborted frame, all outputs at reset values, and 0x5A is received correctly.
REQ-031 Line ±2% baud error (229 and 239 clocks/bit) with 0xC3 -> o_Rx_Byte=0xC3 with o_Rx_Valid asserted in both cases.
